// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - decoded scan-code stream between the PS/2 receiver and its consumer
interface ps2_rx_fifo_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_break;

  // Receiver side drives the head entry and sees the consumer's ready.
  modport master (
    output out_valid,
    output out_code,
    output out_ext,
    output out_break,
    input  out_ready
  );

  // Consumer side.
  modport slave (
    input  out_valid,
    input  out_code,
    input  out_ext,
    input  out_break,
    output out_ready
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with prefix folding and scan-code FIFO
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          clr_overflow,
  ps2_rx_fifo_if.master                 out_if,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [3:0]    LAST_BIT = 4'd10;
  localparam logic [7:0]    CODE_EXT = 8'hE0;
  localparam logic [7:0]    CODE_BRK = 8'hF0;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_fall;
  logic                   w_bit;

  logic [3:0]    r_count;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_tmo;
  logic          r_ext;
  logic          r_brk;
  logic          r_push_pend;
  logic [9:0]    r_push_data;
  logic          r_frame_err;

  logic [7:0] w_code;
  logic       w_frame_ok;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill;
  logic          r_ovf;
  logic          w_valid;
  logic          w_pop;
  logic          w_full;
  logic          w_push_ok;
  logic          w_drop;
  logic [9:0]    w_head;

  // Two-pin synchroniser; both chains idle high so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Data is taken from the stage that holds the same sample time as the post-edge clock stage.
  assign w_fall = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_bit  = r_dat_sync[SYNC_STAGES-2];

  // The stop bit is judged straight from the pin sample on the evaluating fall.
  assign w_code     = r_shift[8:1];
  assign w_frame_ok = ~r_shift[0] & w_bit & (^{w_code, r_shift[9]});

  // Deframer, inactivity timeout and prefix folding; results leave one cycle after the fall.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count     <= '0;
      r_shift     <= '0;
      r_tmo       <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_push_pend <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_push_pend <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_tmo <= '0;
        if (r_count == LAST_BIT) begin
          r_count <= '0;
          if (!w_frame_ok) begin
            r_frame_err <= 1'b1;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
          end else if (w_code == CODE_EXT) begin
            r_ext <= 1'b1;
          end else if (w_code == CODE_BRK) begin
            r_brk <= 1'b1;
          end else begin
            r_push_pend <= 1'b1;
            r_push_data <= {r_ext, r_brk, w_code};
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
          end
        end else begin
          r_shift[r_count] <= w_bit;
          r_count          <= r_count + 4'd1;
        end
      end else if (r_count == 4'd0) begin
        r_tmo <= '0;
      end else if (r_tmo == TMO_MAX) begin
        r_count     <= '0;
        r_tmo       <= '0;
        r_ext       <= 1'b0;
        r_brk       <= 1'b0;
        r_frame_err <= 1'b1;
      end else begin
        r_tmo <= r_tmo + TMO_ONE;
      end
    end
  end

  // A full FIFO still takes the new code when the head leaves in the same cycle.
  assign w_valid   = (r_fill != '0);
  assign w_pop     = w_valid & out_if.out_ready;
  assign w_full    = (r_fill == FULL_LVL);
  assign w_push_ok = r_push_pend & (~w_full | w_pop);
  assign w_drop    = r_push_pend & w_full & ~w_pop;

  // Entry storage; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (resetn && w_push_ok) begin
      r_mem[r_wr_ptr] <= r_push_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_fill <= r_fill + LVL_ONE;
        2'b01:   r_fill <= r_fill - LVL_ONE;
        default: r_fill <= r_fill;
      endcase
      r_ovf <= w_drop | (r_ovf & ~clr_overflow);
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign out_if.out_valid = w_valid;
  assign out_if.out_code  = w_valid ? w_head[7:0] : 8'h00;
  assign out_if.out_break = w_valid & w_head[8];
  assign out_if.out_ext   = w_valid & w_head[9];
  assign fill_level       = r_fill;
  assign frame_err        = r_frame_err;
  assign overflow         = r_ovf;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
  localparam int SYNC_STAGES    = 3;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HALF           = 20;
  localparam int FLW            = $clog2(FIFO_DEPTH) + 1;
  localparam int NVEC           = 15;
  localparam int NRAND          = 40;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           ps2_clk = 1'b1;
  logic           ps2_data = 1'b1;
  logic           clr_overflow = 1'b0;
  logic [FLW-1:0] fill_level;
  logic           frame_err;
  logic           overflow;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .clr_overflow (clr_overflow),
    .out_if       (bus.master),
    .fill_level   (fill_level),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  bit mon_en = 1'b0;
  logic [9:0] model_q[$];

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_start;
    bit         bad_stop;
    bit         exp_q;
    logic [9:0] exp_entry;
    bit         exp_err;
  } vec_t;

  vec_t vt[NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_start, input bit bad_stop);
    logic [10:0] f;
    f[0]   = bad_start;
    f[8:1] = code;
    f[9]   = ~(^code) ^ bad_par;
    f[10]  = ~bad_stop;
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    tick(10);
  endtask

  task automatic pop1();
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, bus.out_valid, 0);
    chk({nm, "_code"}, bus.out_code, 0);
    chk({nm, "_ext"}, bus.out_ext, 0);
    chk({nm, "_break"}, bus.out_break, 0);
    chk({nm, "_fill"}, fill_level, 0);
    chk({nm, "_frame_err"}, frame_err, 0);
    chk({nm, "_overflow"}, overflow, 0);
  endtask

  always @(negedge clk) begin
    if (resetn && frame_err) err_seen++;
  end

  // Scoreboard: every accepted pop must match the oldest code the model queued.
  always @(negedge clk) begin
    logic [9:0] exp_e;
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (model_q.size() == 0) begin
        chk("rand_pop_unexpected", {bus.out_ext, bus.out_break, bus.out_code}, 10'h3FF);
      end else begin
        exp_e = model_q.pop_front();
        chk("rand_pop_entry", {bus.out_ext, bus.out_break, bus.out_code}, exp_e);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [7:0] seq [5];
    logic [7:0] rcode;
    bit rbad;
    bit m_ext;
    bit m_brk;
    bit exp_ovf;

    vt[0]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b0};
    vt[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
    vt[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
    vt[3]  = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 10'h375, 1'b0};
    vt[4]  = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 10'h075, 1'b0};
    vt[5]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1};
    vt[6]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b0};
    vt[7]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
    vt[8]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1};
    vt[9]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b0};
    vt[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
    vt[11] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
    vt[12] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1};
    vt[13] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
    vt[14] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 10'h15A, 1'b0};

    bus.out_ready = 1'b0;

    // Reset state
    resetn = 1'b0;
    tick(3);
    chk_all_zero("reset");
    resetn = 1'b1;
    tick(5);

    // Single code, held until the consumer takes it
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("single_valid", bus.out_valid, 1);
    chk("single_code", bus.out_code, 8'h1C);
    chk("single_flags", {bus.out_ext, bus.out_break}, 2'b00);
    chk("single_fill", fill_level, 1);
    pop1();
    chk("single_after_pop_valid", bus.out_valid, 0);
    chk("single_empty_code", bus.out_code, 0);

    // Table-driven frames: framing errors, prefixes and flag clearing
    for (int i = 0; i < NVEC; i++) begin
      e0 = err_seen;
      send_frame(vt[i].code, vt[i].bad_par, vt[i].bad_start, vt[i].bad_stop);
      chk($sformatf("vec%0d_err", i), err_seen - e0, vt[i].exp_err);
      chk($sformatf("vec%0d_fill", i), fill_level, vt[i].exp_q);
      if (vt[i].exp_q) begin
        chk($sformatf("vec%0d_entry", i), {bus.out_ext, bus.out_break, bus.out_code}, vt[i].exp_entry);
        pop1();
        chk($sformatf("vec%0d_popped", i), bus.out_valid, 0);
      end
    end

    // Overflow: fifth code dropped, order preserved, flag sticky until cleared
    seq[0] = 8'h16; seq[1] = 8'h1E; seq[2] = 8'h26; seq[3] = 8'h25; seq[4] = 8'h2E;
    for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b0, 1'b0, 1'b0);
    chk("ovf_fill", fill_level, FIFO_DEPTH);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain%0d", i), bus.out_code, seq[i]);
      pop1();
    end
    chk("ovf_drained_fill", fill_level, 0);
    chk("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Timeout on a partial frame, then a clean frame
    e0 = err_seen;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data = 1'b1;
    tick(TIMEOUT_CYCLES + 10);
    chk("tmo_err", err_seen - e0, 1);
    chk("tmo_fill", fill_level, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("tmo_next_fill", fill_level, 1);
    chk("tmo_next_code", bus.out_code, 8'h1C);
    chk("tmo_no_extra_err", err_seen - e0, 1);
    pop1();

    // Reset in the middle of a third frame
    send_frame(8'h16, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b0, 1'b0);
    chk("mid_pre_fill", fill_level, 2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b0;
    tick(HALF / 2);
    resetn = 1'b0;
    tick(2);
    chk_all_zero("mid_reset");
    ps2_data = 1'b1;
    resetn = 1'b1;
    tick(5);
    chk("mid_after_fill", fill_level, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("mid_next_fill", fill_level, 1);
    chk("mid_next_entry", {bus.out_ext, bus.out_break, bus.out_code}, 10'h01C);
    pop1();

    // Randomized traffic against a queue model of the prefix/FIFO rules
    mon_en = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    for (int k = 0; k < NRAND; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    rcode = 8'hE0;
        2, 3:    rcode = 8'hF0;
        default: rcode = 8'($urandom_range(0, 255));
      endcase
      rbad = ($urandom_range(0, 9) == 0);
      exp_ovf = 1'b0;
      bus.out_ready = 1'b0;
      tick(2);
      e0 = err_seen;
      send_frame(rcode, rbad, 1'b0, 1'b0);
      if (rbad) begin
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (rcode == 8'hE0) begin
        m_ext = 1'b1;
      end else if (rcode == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        if (model_q.size() < FIFO_DEPTH) model_q.push_back({m_ext, m_brk, rcode});
        else exp_ovf = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      chk($sformatf("rand%0d_err", k), err_seen - e0, rbad);
      chk($sformatf("rand%0d_fill", k), fill_level, model_q.size());
      chk($sformatf("rand%0d_ovf", k), overflow, exp_ovf);
      if (exp_ovf) begin
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
      end
      for (int g = 0; g < int'($urandom_range(0, 10)); g++) begin
        bus.out_ready = ($urandom_range(0, 3) == 0);
        tick(1);
      end
      bus.out_ready = 1'b0;
      tick(1);
    end
    bus.out_ready = 1'b1;
    tick(FIFO_DEPTH + 2);
    bus.out_ready = 1'b0;
    tick(1);
    chk("rand_drain_fill", fill_level, 0);
    chk("rand_drain_valid", bus.out_valid, 0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 keyboard receiver. It synchronises ps2_clk and ps2_data, deframes 11-bit frames and checks start, odd parity and stop.
- It folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags and queues decoded scan codes in a FIFO with a valid/ready read port.
- It sits between the PS/2 pins and the keyboard-to-ASCII/display logic. It replaces print-only receivers with a consumable stream carrying error and overflow reporting.

Parameters:
- SYNC_STAGES, 3, depth of the ps2_clk/ps2_data synchroniser chain (legal values are 2 or more).
- FIFO_DEPTH, 8, number of queued entries (power of 2, 2 or more).
- TIMEOUT_CYCLES, 50000, clk cycles without a falling ps2_clk edge before a partial frame is abandoned (1 or more).

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- ps2_clk  input  1  asynchronous PS/2 clock from the pin.
- ps2_data  input  1  asynchronous PS/2 data from the pin.
- out_ready  input  1  consumer accepts the head entry.
- clr_overflow  input  1  clears the sticky overflow flag.
- out_valid  output  1  FIFO not empty.
- out_code  output  8  head entry scan code.
- out_ext  output  1  head entry was preceded by 0xE0.
- out_break  output  1  head entry was preceded by 0xF0.
- fill_level  output  $clog2(FIFO_DEPTH)+1  number of entries held.
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- overflow  output  1  sticky; set when a code is dropped because the FIFO is full.

Behaviour:
- Reset (resetn low at a clk edge) produces:
  - out_valid=0, out_code=0, out_ext=0, out_break=0, fill_level=0, frame_err=0, overflow=0.
  - Bit counter=0, prefix flags=0, timeout counter=0, FIFO pointers=0.
  - Synchroniser chains are loaded with all ones (idle bus).
- Reset mid-frame discards the partial frame and all FIFO contents.
- Synchroniser and edge detection: each input shifts through SYNC_STAGES flops.
  - fall = (oldest stage is 1) and (next stage is 0). This is a one-cycle pulse.
  - Data is sampled from the synchronised ps2_data stage aligned with the same ps2_clk stage.
- Deframer: a bit counter runs 0..10. On each fall, the bit is stored at index count.
  - Bit 0 is start, bits 1-8 are data LSB-first, bit 9 is parity, bit 10 is stop.
  - On the fall at count=10 the frame is evaluated and count returns to 0.
  - The frame is valid when start==0, stop==1, and the XOR of data[7:0] and parity equals 1 (odd parity).
  - An invalid frame is discarded: frame_err pulses high in the cycle after the evaluating fall, and both prefix flags clear.
- Timeout: the timeout counter clears on every fall and while count==0; otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYCLES, count and the timeout counter reset to 0, the prefix flags clear, and frame_err pulses for one cycle.
- Prefix folding for valid frames:
  - 0xE0 sets ext_flag and 0xF0 sets brk_flag. Neither is queued.
  - Any other code is pushed as {ext_flag, brk_flag, code}, and both flags clear in the same cycle, whether or not the push succeeds.
  - A repeated prefix leaves its flag set.
- FIFO: each entry is 10 bits. The head is presented combinationally from storage, and out_valid = (fill_level != 0).
  - Pop occurs when out_valid && out_ready.
  - Push occurs on the cycle after the evaluating fall.
  - Push latency: the code appears on out_valid no earlier than 2 cycles after the fall that sampled the stop bit, i.e. fall cycle N, push at end of N+1, visible in N+2.
  - If the FIFO is full and there is no simultaneous pop, the push is dropped and overflow is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted and fill_level is unchanged.
  - If the FIFO is empty, push and pop cannot coincide (out_valid is 0).
  - Pointers wrap modulo FIFO_DEPTH.
  - out_code, out_ext and out_break are 0 while the FIFO is empty.
- overflow stays high until clr_overflow is sampled high. If a drop and clr_overflow coincide, overflow stays set.
- Glitches: the synchroniser filters nothing beyond metastability. The ps2_clk bus is assumed to be driven at the protocol rate (10-16.7 kHz, far below clk).

Test Plan:
- Single code: send frame 0x1C with parity 0 and stop 1, out_ready=0 -> out_valid=1, out_code=0x1C, ext=0, break=0, fill_level=1. Raise out_ready for one cycle -> out_valid=0.
- Prefix fold: send 0xE0, 0xF0, 0x75 -> exactly one entry: code 0x75, ext=1, break=1. Then send 0x75 -> entry 0x75 with ext=0, break=0.
- Parity error: send 0x1C with parity 1 -> frame_err pulses once, no entry queued. A following good 0x1C frame is queued normally.
- Overflow with FIFO_DEPTH=4, out_ready=0: send 0x16, 0x1E, 0x26, 0x25, 0x2E.
  - fill_level=4 and overflow=1.
  - Draining yields 0x16, 0x1E, 0x26, 0x25 in order.
  - Pulsing clr_overflow gives overflow=0.
- Timeout: send 5 bits, idle for TIMEOUT_CYCLES+10 -> frame_err pulses once and count returns to 0. A following full 0x1C frame is received correctly.
- Reset mid-frame: with 2 entries queued, assert resetn=0 during bit 4 of a third frame -> all outputs are 0 after reset. The next clean 0x1C frame is received as the only entry.
